axi4_slave_mem: RTL and testbench

- AXI4 responder backed by an internal word-addressed memory; the target end of the frame-buffer master (128-bit data, 28-bit byte address, 16-beat INCR bursts).
- Used as the DDR3/MIG stand-in in simulation and as an on-chip BRAM target for small-frame bring-up.
- Write and read channels run independently, each with one outstanding burst.

---
 rtl/axi4_pkg.sv | 12 +
 rtl/axi4_slave_mem_if.sv | 47 ++++
 rtl/axi4_sdp_ram.sv | 21 ++
 rtl/axi4_slave_mem.sv | 121 ++++++++++++
 tb/tb_axi4_slave_mem.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 widths, response codes and FSM state types for the frame-buffer memory path
package axi4_pkg;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int ID_W = 4;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi4_slave_mem_if.sv
// axi4_slave_mem_if: AXI4 bus bundle between the frame-buffer master and the memory responder
interface axi4_slave_mem_if;
  import axi4_pkg::*;
  logic [ID_W-1:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ID_W-1:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready;
  logic [ID_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid,
    input wdata, wstrb, wlast, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awready, wready, bid, bresp, bvalid,
    input arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_sdp_ram.sv
// axi4_sdp_ram: simple dual-port RAM, byte-enable write port and registered read port (read-during-write gives old data)
module axi4_sdp_ram #(
  parameter int WORDS = 4096,
  parameter int DW = 128
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(WORDS)-1:0] waddr,
  input  logic [DW/8-1:0] wstrb,
  input  logic [DW-1:0] wdata,
  input  logic re,
  input  logic [$clog2(WORDS)-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [WORDS];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < DW/8; i++)
      if (we && wstrb[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
  end
endmodule

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 INCR-burst responder over a word-addressed RAM; independent write and read FSMs,
// one outstanding burst each
module axi4_slave_mem import axi4_pkg::*; #(
  parameter int MEM_WORDS = 4096
) (
  input logic sclk,
  input logic s_rst,
  axi4_slave_mem_if.slave s_axi
);
  localparam int IW = $clog2(MEM_WORDS);
  w_state_t wst;
  r_state_t rst_q;
  logic [IW-1:0] widx, ridx, ram_raddr;
  logic [7:0] wlen, wbeat, rlen, rbeat;
  logic werr, aw_hs, w_hs, ar_hs, r_hs, w_end, w_err_n, ram_re;
  logic unused_ok;
  assign unused_ok = ^{s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst,
                       s_axi.awaddr[ADDR_W-1:IW+4], s_axi.awaddr[3:0],
                       s_axi.araddr[ADDR_W-1:IW+4], s_axi.araddr[3:0]};
  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs = s_axi.rvalid && s_axi.rready;
  assign w_end = wbeat == wlen;
  assign w_err_n = werr | (s_axi.wlast ^ w_end);
  // The RAM output register is rdata itself: fetch on AR, or on each non-final R handshake, and hold otherwise
  assign ram_re = ar_hs || (r_hs && !s_axi.rlast);
  assign ram_raddr = ar_hs ? s_axi.araddr[IW+3:4] : ridx + 1'b1;
  assign s_axi.rresp = RESP_OKAY;
  axi4_sdp_ram #(.WORDS(MEM_WORDS), .DW(DATA_W)) u_ram (
    .clk(sclk),
    .we(w_hs),
    .waddr(widx),
    .wstrb(s_axi.wstrb),
    .wdata(s_axi.wdata),
    .re(ram_re),
    .raddr(ram_raddr),
    .rdata(s_axi.rdata)
  );
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      wst <= W_IDLE;
      s_axi.awready <= 1'b1;
      s_axi.wready <= 1'b0;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp <= RESP_OKAY;
      s_axi.bid <= '0;
      widx <= '0;
      wlen <= '0;
      wbeat <= '0;
      werr <= 1'b0;
    end else begin
      case (wst)
        W_IDLE: if (aw_hs) begin
          s_axi.bid <= s_axi.awid;
          widx <= s_axi.awaddr[IW+3:4];
          wlen <= s_axi.awlen;
          wbeat <= '0;
          werr <= 1'b0;
          s_axi.awready <= 1'b0;
          s_axi.wready <= 1'b1;
          wst <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          widx <= widx + 1'b1;
          wbeat <= wbeat + 1'b1;
          werr <= w_err_n;
          if (w_end) begin
            s_axi.wready <= 1'b0;
            s_axi.bvalid <= 1'b1;
            s_axi.bresp <= w_err_n ? RESP_SLVERR : RESP_OKAY;
            wst <= W_RESP;
          end
        end
        default: if (s_axi.bready) begin
          s_axi.bvalid <= 1'b0;
          s_axi.bresp <= RESP_OKAY;
          s_axi.awready <= 1'b1;
          wst <= W_IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      rst_q <= R_IDLE;
      s_axi.arready <= 1'b1;
      s_axi.rvalid <= 1'b0;
      s_axi.rlast <= 1'b0;
      s_axi.rid <= '0;
      ridx <= '0;
      rlen <= '0;
      rbeat <= '0;
    end else begin
      case (rst_q)
        R_IDLE: if (ar_hs) begin
          s_axi.rid <= s_axi.arid;
          ridx <= s_axi.araddr[IW+3:4];
          rlen <= s_axi.arlen;
          rbeat <= '0;
          s_axi.rlast <= s_axi.arlen == 8'd0;
          s_axi.rvalid <= 1'b1;
          s_axi.arready <= 1'b0;
          rst_q <= R_DATA;
        end
        default: if (r_hs) begin
          if (s_axi.rlast) begin
            s_axi.rvalid <= 1'b0;
            s_axi.rlast <= 1'b0;
            s_axi.arready <= 1'b1;
            rst_q <= R_IDLE;
          end else begin
            ridx <= ridx + 1'b1;
            rbeat <= rbeat + 1'b1;
            s_axi.rlast <= rbeat + 8'd1 == rlen;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb_axi4_slave_mem: table-driven burst vectors against a byte-lane reference memory, plus a mid-read reset sequence
module tb_axi4_slave_mem;
  typedef struct {
    bit wr;
    bit tog;
    logic [3:0] id;
    logic [27:0] addr;
    logic [7:0] len;
    logic [127:0] dat;
    logic [15:0] strb;
    int wl;
    logic [1:0] resp;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [127:0] model [4096];
  vec_t tbl [12];
  axi4_slave_mem_if bus ();
  axi4_slave_mem #(.MEM_WORDS(4096)) dut (.sclk(clk), .s_rst(rst), .s_axi(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_ready(input bit aw);
    int n = 0;
    while (!(aw ? bus.awready : bus.arready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(aw ? bus.awready : bus.arready)) chk(aw ? "awready_timeout" : "arready_timeout", 0, 1);
  endtask
  task automatic do_write(input vec_t v);
    logic [11:0] w;
    logic [127:0] d;
    @(negedge clk);
    bus.awid = v.id;
    bus.awaddr = v.addr;
    bus.awlen = v.len;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    bus.wdata = v.dat;
    bus.wstrb = v.strb;
    bus.wlast = v.wl == 0;
    wait_ready(1'b1);
    chk("wready_during_aw", bus.wready, 0);
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int k = 0; k <= int'(v.len); k++) begin
      d = v.dat + 128'(k);
      bus.wdata = d;
      bus.wlast = k == v.wl;
      chk("wready_beat", bus.wready, 1);
      w = v.addr[15:4] + 12'(k);
      for (int i = 0; i < 16; i++) if (v.strb[i]) model[w][i*8 +: 8] = d[i*8 +: 8];
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    chk("bvalid_after_last", bus.bvalid, 1);
    chk("bid", bus.bid, v.id);
    chk("bresp", bus.bresp, v.resp);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    chk("awready_after_b", bus.awready, 1);
    chk("bvalid_after_b", bus.bvalid, 0);
  endtask
  task automatic do_read(input vec_t v);
    int k = 0;
    int n = 0;
    bit stalled = 1'b0;
    logic [127:0] held = '0;
    logic [11:0] w;
    @(negedge clk);
    bus.arid = v.id;
    bus.araddr = v.addr;
    bus.arlen = v.len;
    bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    wait_ready(1'b0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rvalid_ar_plus1", bus.rvalid, 1);
    chk("rdata_first", bus.rdata, v.dat);
    while (k <= int'(v.len) && n < 200) begin
      bus.rready = v.tog ? (n % 2 == 0) : 1'b1;
      if (stalled) chk("rdata_hold", bus.rdata, held);
      chk("rvalid_beat", bus.rvalid, 1);
      if (bus.rready) begin
        w = v.addr[15:4] + 12'(k);
        chk("rdata_beat", bus.rdata, model[w]);
        chk("rlast_beat", bus.rlast, k == int'(v.len));
        chk("rid", bus.rid, v.id);
        k++;
        stalled = 1'b0;
      end else begin
        held = bus.rdata;
        stalled = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.rready = 1'b0;
    if (k <= int'(v.len)) chk("read_beats_timeout", 128'(k), 128'(v.len) + 1);
    chk("arready_after_last", bus.arready, 1);
    chk("rvalid_after_last", bus.rvalid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{1, 0, 4'd3,  28'h100,   8'd15, 128'h0, 16'hFFFF, 15, 2'b00};
    tbl[1]  = '{0, 0, 4'd5,  28'h100,   8'd15, 128'h0, 16'hFFFF, 0,  2'b00};
    tbl[2]  = '{0, 1, 4'd5,  28'h100,   8'd15, 128'h0, 16'hFFFF, 0,  2'b00};
    tbl[3]  = '{1, 0, 4'd1,  28'h2000,  8'd0,  {128{1'b1}}, 16'hFFFF, 0, 2'b00};
    tbl[4]  = '{1, 0, 4'd2,  28'h2000,  8'd0,  128'h0123456789abcdef_fedcba9876543210, 16'h00FF, 0, 2'b00};
    tbl[5]  = '{0, 0, 4'd6,  28'h2000,  8'd0,  128'hFFFFFFFFFFFFFFFF_fedcba9876543210, 16'hFFFF, 0, 2'b00};
    tbl[6]  = '{1, 0, 4'd7,  28'h300,   8'd15, 128'h100, 16'hFFFF, 7, 2'b10};
    tbl[7]  = '{0, 0, 4'd8,  28'h300,   8'd15, 128'h100, 16'hFFFF, 0, 2'b00};
    tbl[8]  = '{1, 0, 4'd9,  28'hFFE0,  8'd3,  128'hA0, 16'hFFFF, 3, 2'b00};
    tbl[9]  = '{0, 0, 4'd10, 28'h0,     8'd1,  128'hA2, 16'hFFFF, 0, 2'b00};
    tbl[10] = '{0, 1, 4'd11, 28'hFFE0,  8'd3,  128'hA0, 16'hFFFF, 0, 2'b00};
    tbl[11] = '{0, 0, 4'd12, 28'h1010F, 8'd2,  128'h0, 16'hFFFF, 0, 2'b00};
    rst = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd4; bus.awburst = 2'b01; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd4; bus.arburst = 2'b01; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", bus.awready, 1);
    chk("rst_arready", bus.arready, 1);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_ids_resps", {bus.bid, bus.rid, bus.bresp, bus.rresp}, 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].wr) do_write(tbl[i]);
      else do_read(tbl[i]);
    end
    @(negedge clk);
    bus.arid = 4'd13;
    bus.araddr = 28'h100;
    bus.arlen = 8'd15;
    bus.arvalid = 1'b1;
    wait_ready(1'b0);
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midread_rdata", bus.rdata, 128'd3);
    bus.rready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rvalid", bus.rvalid, 0);
    chk("midrst_rlast", bus.rlast, 0);
    chk("midrst_arready", bus.arready, 1);
    chk("midrst_rid", bus.rid, 0);
    do_read(tbl[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
